// File: rtl/util_scaler_pkg.sv
// Shared types and widths for the block-floating-point scaler gain controller.
// Holds the FSM encoding, the monitor bundle layout and a small resolution helper.
package util_scaler_pkg;

    localparam int AGC_ADDEND_WIDTH = 6;
    localparam int EXP_W            = 6;
    localparam int RES_W            = 6;
    localparam int FLAG_W           = 2;

    localparam logic [RES_W-1:0] RES_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_HOLD   = 2'd3
    } agc_state_e;

    typedef struct packed {
        logic              valid;
        logic              sop;
        logic              eop;
        logic [FLAG_W-1:0] ovf;
        logic [FLAG_W-1:0] unf;
        logic [RES_W-1:0]  res;
    } mon_t;

    function automatic logic [RES_W-1:0] res_min_f(input logic [RES_W-1:0] a,
                                                   input logic [RES_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

endpackage

// File: rtl/util_sat_counter.sv
// Saturating up-counter: clear wins over increment, clear+inc restarts at 1.
// Latency: count visible the cycle after inc; no backpressure, holds at all-ones.
module util_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {{(WIDTH-1){1'b0}}, inc};
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/util_scaler_agc.sv
// Frame-rate AGC: steps the scaler exponent addend by one at frame ends to keep output in window.
// Latency: addend/addend_update registered, visible two cycles after the eop sample; no backpressure.
// UTIL_SCALER_AGC_STATS_EN adds saturating frame/step/error statistics outputs.
module util_scaler_agc
    import util_scaler_pkg::*;
#(
    parameter int ADDEND_WIDTH = AGC_ADDEND_WIDTH,
    parameter int ADDEND_INIT  = 0,
    parameter int ADDEND_MIN   = -4,
    parameter int ADDEND_MAX   = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_enable,
    input  logic [CNT_WIDTH-1:0]    cfg_ovf_thresh,
    input  logic [RES_W-1:0]        cfg_res_target,
    input  logic [3:0]              cfg_hold_frames,
    input  logic                    mon_valid,
    input  logic                    mon_sop,
    input  logic                    mon_eop,
    input  logic [FLAG_W-1:0]       mon_overflow,
    input  logic [FLAG_W-1:0]       mon_underflow,
    input  logic [RES_W-1:0]        mon_resolution,
    output logic [ADDEND_WIDTH-1:0] addend,
    output logic                    addend_update,
    output logic                    frame_err,
    output logic [1:0]              state_dbg
`ifdef UTIL_SCALER_AGC_STATS_EN
    ,
    output logic [31:0]             stat_frames,
    output logic [15:0]             stat_steps_up,
    output logic [15:0]             stat_steps_down,
    output logic [15:0]             stat_frame_errs
`endif
);

    localparam logic signed [ADDEND_WIDTH-1:0] A_INIT = ADDEND_INIT[ADDEND_WIDTH-1:0];
    localparam logic signed [ADDEND_WIDTH-1:0] A_MIN  = ADDEND_MIN[ADDEND_WIDTH-1:0];
    localparam logic signed [ADDEND_WIDTH-1:0] A_MAX  = ADDEND_MAX[ADDEND_WIDTH-1:0];
    localparam logic [ADDEND_WIDTH-1:0]        A_ONE  = {{(ADDEND_WIDTH-1){1'b0}}, 1'b1};

    mon_t mon;
    assign mon = '{valid: mon_valid, sop: mon_sop, eop: mon_eop,
                   ovf: mon_overflow, unf: mon_underflow, res: mon_resolution};

    agc_state_e                      state_q;
    logic signed [ADDEND_WIDTH-1:0]  addend_q;
    logic                            addend_update_q;
    logic                            frame_err_q;
    logic                            enable_q;
    logic [RES_W-1:0]                res_min_q;
    logic [3:0]                      hold_q;

    logic                 v_sop, v_eop;
    logic                 cnt_clr, cnt_inc, ovf_inc;
    logic [CNT_WIDTH-1:0] ovf_cnt, sample_cnt;
    logic                 want_up, want_dn, do_up, do_dn;

    assign v_sop = mon.valid & mon.sop;
    assign v_eop = mon.valid & mon.eop;

    // Counters clear outside FRAME; the frame-opening sample loads them to 1 via clr+inc.
    always_comb begin
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE:  cnt_inc = v_sop;
            ST_FRAME: begin
                cnt_clr = v_sop;
                cnt_inc = mon.valid;
            end
            default: ;
        endcase
        if (!cfg_enable) begin
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
        ovf_inc = cnt_inc & (|mon.ovf);
    end

    util_sat_counter #(.WIDTH(CNT_WIDTH)) u_ovf_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(ovf_inc), .cnt(ovf_cnt)
    );

    util_sat_counter #(.WIDTH(CNT_WIDTH)) u_sample_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_inc), .cnt(sample_cnt)
    );

    // Overflow and resolution tests are exclusive because they disagree on ovf_cnt==0.
    assign want_up = (ovf_cnt != '0) && (ovf_cnt >= cfg_ovf_thresh);
    assign want_dn = (ovf_cnt == '0) && (res_min_q < cfg_res_target);
    assign do_up   = (state_q == ST_DECIDE) && want_up && (addend_q < A_MAX);
    assign do_dn   = (state_q == ST_DECIDE) && want_dn && (addend_q > A_MIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addend_q        <= A_INIT;
            addend_update_q <= 1'b0;
            frame_err_q     <= 1'b0;
            enable_q        <= 1'b0;
            res_min_q       <= RES_MAX;
            hold_q          <= '0;
        end else begin
            addend_update_q <= 1'b0;
            frame_err_q     <= 1'b0;
            enable_q        <= cfg_enable;
            if (!cfg_enable) begin
                state_q   <= ST_IDLE;
                res_min_q <= RES_MAX;
                hold_q    <= '0;
            end else begin
                if (!enable_q) begin
                    addend_q <= A_INIT;
                end
                case (state_q)
                    ST_IDLE: begin
                        res_min_q <= RES_MAX;
                        if (v_sop) begin
                            res_min_q <= mon.res;
                            state_q   <= v_eop ? ST_DECIDE : ST_FRAME;
                        end else if (v_eop) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    ST_FRAME: begin
                        if (mon.valid) begin
                            if (mon.sop) begin
                                frame_err_q <= 1'b1;
                                res_min_q   <= mon.res;
                            end else begin
                                res_min_q <= res_min_f(res_min_q, mon.res);
                            end
                            if (mon.eop) begin
                                state_q <= ST_DECIDE;
                            end
                        end
                    end
                    ST_DECIDE: begin
                        res_min_q <= RES_MAX;
                        if (do_up || do_dn) begin
                            addend_q        <= do_up ? addend_q + A_ONE : addend_q - A_ONE;
                            addend_update_q <= 1'b1;
                            hold_q          <= cfg_hold_frames;
                            state_q         <= ST_HOLD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (hold_q == '0) begin
                            state_q <= ST_IDLE;
                        end else if (v_eop) begin
                            hold_q <= hold_q - 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign addend        = addend_q;
    assign addend_update = addend_update_q;
    assign frame_err     = frame_err_q;
    assign state_dbg     = state_q;

    logic unused_mon;
    assign unused_mon = ^{mon.unf, sample_cnt};

`ifdef UTIL_SCALER_AGC_STATS_EN
    util_sat_counter #(.WIDTH(32)) u_stat_frames (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(state_q == ST_DECIDE), .cnt(stat_frames)
    );
    util_sat_counter #(.WIDTH(16)) u_stat_up (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(do_up), .cnt(stat_steps_up)
    );
    util_sat_counter #(.WIDTH(16)) u_stat_dn (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(do_dn), .cnt(stat_steps_down)
    );
    util_sat_counter #(.WIDTH(16)) u_stat_err (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(frame_err_q), .cnt(stat_frame_errs)
    );
`endif

endmodule

// File: tb/tb_util_scaler_agc.sv
// Scoreboard bench for util_scaler_agc: frame stimulus pushes expected addend/pulse, checked after DECIDE.
module tb_util_scaler_agc;
    import util_scaler_pkg::*;

    localparam int AW     = 6;
    localparam int THRESH = 4;
    localparam int TARGET = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic [15:0] cfg_ovf_thresh;
    logic [5:0]  cfg_res_target;
    logic [3:0]  cfg_hold_frames;
    logic        mon_valid, mon_sop, mon_eop;
    logic [1:0]  mon_overflow, mon_underflow;
    logic [5:0]  mon_resolution;
    logic [AW-1:0] addend;
    logic        addend_update, frame_err;
    logic [1:0]  state_dbg;
`ifdef UTIL_SCALER_AGC_STATS_EN
    logic [31:0] stat_frames;
    logic [15:0] stat_steps_up, stat_steps_down, stat_frame_errs;
`endif

    always #5 clk = ~clk;

    util_scaler_agc dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_ovf_thresh(cfg_ovf_thresh),
        .cfg_res_target(cfg_res_target), .cfg_hold_frames(cfg_hold_frames),
        .mon_valid(mon_valid), .mon_sop(mon_sop), .mon_eop(mon_eop),
        .mon_overflow(mon_overflow), .mon_underflow(mon_underflow),
        .mon_resolution(mon_resolution), .addend(addend), .addend_update(addend_update),
        .frame_err(frame_err), .state_dbg(state_dbg)
`ifdef UTIL_SCALER_AGC_STATS_EN
        , .stat_frames(stat_frames), .stat_steps_up(stat_steps_up),
        .stat_steps_down(stat_steps_down), .stat_frame_errs(stat_frame_errs)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_upd    = 0;
    int n_ferr   = 0;
    int model_add = 0;
    logic [AW-1:0] exp_add_q[$];
    logic          exp_pls_q[$];
    logic [AW-1:0] exp_add;
    logic          exp_pls;

    always @(negedge clk) begin
        if (addend_update === 1'b1) n_upd++;
        if (frame_err === 1'b1) n_ferr++;
    end

    function automatic int judge(input int a, input int ovf, input int res);
        int r;
        r = a;
        if (ovf >= THRESH && ovf != 0) r = a + 1;
        else if (ovf == 0 && res < TARGET) r = a - 1;
        if (r > 8) r = 8;
        if (r < -4) r = -4;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mon_valid = 1'b0; mon_sop = 1'b0; mon_eop = 1'b0;
        mon_overflow = 2'b00; mon_underflow = 2'b00;
    endtask

    task automatic drive_sample(input logic sop, input logic eop, input logic ovf, input int res);
        mon_valid = 1'b1; mon_sop = sop; mon_eop = eop;
        mon_overflow = ovf ? 2'b10 : 2'b00;
        mon_underflow = 2'b01;
        mon_resolution = res[5:0];
        tick();
    endtask

    // Drives one complete frame and records the expected outcome of its end.
    task automatic drive_frame(input int n, input int novf, input int res, input bit judged);
        int nxt;
        for (int i = 0; i < n; i++) drive_sample(i == 0, i == n - 1, i < novf, res);
        idle_in();
        nxt = judged ? judge(model_add, (novf < n) ? novf : n, res) : model_add;
        exp_add_q.push_back(nxt[AW-1:0]);
        exp_pls_q.push_back(nxt != model_add);
        model_add = nxt;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_enable = 1'b0; cfg_ovf_thresh = 16'(THRESH);
        cfg_res_target = 6'(TARGET); cfg_hold_frames = 4'd0; mon_resolution = 6'd20;
        idle_in();
        gap(2);
        n_checks++;
        if (addend !== 6'd0 || addend_update !== 1'b0 || frame_err !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: addend=%0d upd=%b ferr=%b state=%0d, required 0 0 0 0",
                     addend, addend_update, frame_err, state_dbg);
        end
        rst = 1'b0;
        cfg_enable = 1'b1;
        gap(2);
    endtask

    task automatic test_step_up();
        drive_frame(64, 5, 20, 1'b1);
        tick();
        exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
        n_checks++;
        if (addend !== exp_add || addend_update !== exp_pls || state_dbg !== 2'd3) begin
            n_fail++;
            $display("FAIL step_up: addend=%0d upd=%b state=%0d, required %0d %b 3",
                     $signed(addend), addend_update, state_dbg, $signed(exp_add), exp_pls);
        end
        tick();
        n_checks++;
        if (addend_update !== 1'b0) begin
            n_fail++;
            $display("FAIL step_up_pulse_width: upd=%b, required 0", addend_update);
        end
        gap(3);
    endtask

    task automatic test_no_change_then_down();
        drive_frame(64, 3, 20, 1'b1);
        tick();
        exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
        n_checks++;
        if (addend !== exp_add || addend_update !== exp_pls || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL no_change: addend=%0d upd=%b state=%0d, required %0d %b 0",
                     $signed(addend), addend_update, state_dbg, $signed(exp_add), exp_pls);
        end
        gap(3);
        drive_frame(64, 0, 10, 1'b1);
        tick();
        exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
        n_checks++;
        if (addend !== exp_add || addend_update !== exp_pls) begin
            n_fail++;
            $display("FAIL step_down: addend=%0d upd=%b, required %0d %b",
                     $signed(addend), addend_update, $signed(exp_add), exp_pls);
        end
        gap(3);
    endtask

    task automatic test_clamp();
        int upd0;
        for (int f = 0; f < 9; f++) begin
            drive_frame((f == 8) ? 100 : 6, (f == 8) ? 100 : 5, 20, 1'b1);
            upd0 = n_upd;
            tick();
            exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
            n_checks++;
            if (addend !== exp_add || addend_update !== exp_pls) begin
                n_fail++;
                $display("FAIL clamp_max frame %0d: addend=%0d upd=%b, required %0d %b",
                         f, $signed(addend), addend_update, $signed(exp_add), exp_pls);
            end
            gap(3);
        end
        n_checks++;
        if (state_dbg !== 2'd0 || n_upd != upd0) begin
            n_fail++;
            $display("FAIL clamp_max_idle: state=%0d pulses=%0d, required 0 %0d", state_dbg, n_upd, upd0);
        end
    endtask

    task automatic test_enable();
        int upd0;
        upd0 = n_upd;
        for (int i = 0; i < 3; i++) drive_sample(i == 0, 1'b0, 1'b1, 20);
        cfg_enable = 1'b0;
        drive_sample(1'b0, 1'b0, 1'b1, 20);
        n_checks++;
        if (state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL disable_forces_idle: state=%0d, required 0", state_dbg);
        end
        drive_frame(8, 8, 20, 1'b0);
        tick();
        exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
        n_checks++;
        if (addend !== exp_add || n_upd != upd0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL disabled_frozen: addend=%0d pulses=%0d state=%0d, required %0d %0d 0",
                     $signed(addend), n_upd, state_dbg, $signed(exp_add), upd0);
        end
        cfg_enable = 1'b1;
        tick();
        model_add = 0;
        n_checks++;
        if (addend !== 6'd0) begin
            n_fail++;
            $display("FAIL enable_reload: addend=%0d, required 0", $signed(addend));
        end
        gap(2);
        for (int f = 0; f < 5; f++) begin
            drive_frame(4, 0, 10, 1'b1);
            tick();
            exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
            n_checks++;
            if (addend !== exp_add || addend_update !== exp_pls) begin
                n_fail++;
                $display("FAIL clamp_min frame %0d: addend=%0d upd=%b, required %0d %b",
                         f, $signed(addend), addend_update, $signed(exp_add), exp_pls);
            end
            gap(3);
        end
    endtask

    task automatic test_hold();
        cfg_enable = 1'b0; tick(); cfg_enable = 1'b1; tick();
        model_add = 0;
        cfg_hold_frames = 4'd2;
        for (int f = 0; f < 4; f++) begin
            drive_frame(6, 6, 20, (f == 0 || f == 3));
            tick();
            exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
            n_checks++;
            if (addend !== exp_add || addend_update !== exp_pls) begin
                n_fail++;
                $display("FAIL hold frame %0d: addend=%0d upd=%b, required %0d %b",
                         f, $signed(addend), addend_update, $signed(exp_add), exp_pls);
            end
            gap(3);
        end
        n_checks++;
        if (state_dbg !== 2'd3) begin
            n_fail++;
            $display("FAIL hold_reentered: state=%0d, required 3", state_dbg);
        end
    endtask

    task automatic test_frame_err();
        int nxt;
        cfg_hold_frames = 4'd0;
        cfg_enable = 1'b0; tick(); cfg_enable = 1'b1; tick();
        model_add = 0;
        for (int i = 0; i < 30; i++) drive_sample(i == 0, 1'b0, i < 10, 10);
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_early: frame_err=%b, required 0", frame_err);
        end
        drive_sample(1'b1, 1'b0, 1'b0, 10);
        n_checks++;
        if (frame_err !== 1'b1 || state_dbg !== 2'd1) begin
            n_fail++;
            $display("FAIL frame_err_sop: frame_err=%b state=%0d, required 1 1", frame_err, state_dbg);
        end
        for (int i = 0; i < 10; i++) drive_sample(1'b0, i == 9, 1'b0, 10);
        idle_in();
        nxt = judge(model_add, 0, 10);
        exp_add_q.push_back(nxt[AW-1:0]);
        exp_pls_q.push_back(nxt != model_add);
        model_add = nxt;
        tick();
        exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
        n_checks++;
        if (addend !== exp_add || addend_update !== exp_pls) begin
            n_fail++;
            $display("FAIL frame_restart_counts: addend=%0d upd=%b, required %0d %b",
                     $signed(addend), addend_update, $signed(exp_add), exp_pls);
        end
        gap(3);
        drive_sample(1'b0, 1'b1, 1'b0, 20);
        idle_in();
        n_checks++;
        if (frame_err !== 1'b1 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL stray_eop: frame_err=%b state=%0d, required 1 0", frame_err, state_dbg);
        end
        gap(2);
    endtask

    task automatic test_async_reset();
        int upd0, ferr0;
        for (int i = 0; i < 10; i++) drive_sample(i == 0, 1'b0, i < 7, 20);
        upd0 = n_upd; ferr0 = n_ferr;
        rst = 1'b1;
        #2;
        model_add = 0;
        n_checks++;
        if (addend !== 6'd0 || state_dbg !== 2'd0 || addend_update !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: addend=%0d state=%0d upd=%b ferr=%b, required 0 0 0 0",
                     $signed(addend), state_dbg, addend_update, frame_err);
        end
        idle_in();
        #1 rst = 1'b0;
        gap(2);
        drive_frame(8, 3, 20, 1'b1);
        tick();
        exp_add = exp_add_q.pop_front(); exp_pls = exp_pls_q.pop_front();
        n_checks++;
        if (addend !== exp_add || addend_update !== exp_pls || n_upd != upd0 || n_ferr != ferr0) begin
            n_fail++;
            $display("FAIL reset_cleared_counts: addend=%0d upd=%b pulses=%0d errs=%0d, required %0d %b %0d %0d",
                     $signed(addend), addend_update, n_upd, n_ferr, $signed(exp_add), exp_pls, upd0, ferr0);
        end
        gap(2);
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_no_change_then_down();
        test_clamp();
        test_enable();
        test_hold();
        test_frame_err();
        test_async_reset();
        n_checks++;
        if (exp_add_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_add_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
